ex_muldiv: RTL
==============

// Module: ex_muldiv
// PURPOSE
//   Iterative multiply/divide unit in the EX stage; consumes the operand
//   pair the ID/EX pipeline register delivers (data1_o/data2_o).
//   Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring) over DATA_W
//   cycles, writes HI/LO, and drives busy_o back to the hazard unit so
//   IF/ID/EX stall until the result is ready.
// PARAMETERS
//   DATA_W  32  operand width; HI/LO are each DATA_W bits
// PORTS
//   clk_i    in   1       clock
//   rst_i    in   1       reset, synchronous, active-high
//   start_i  in   1       launch op; sampled only when state==IDLE
//   op_i     in   2       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   data1_i  in   DATA_W  rs operand (multiplicand / dividend)
//   data2_i  in   DATA_W  rt operand (multiplier / divisor)
//   flush_i  in   1       abort in-flight op (branch/exception flush)
//   busy_o   out  1       stall request; high whenever state!=IDLE
//   done_o   out  1       one-cycle pulse; HI/LO updated this cycle
//   hi_o     out  DATA_W  HI: product[2W-1:W] / remainder
//   lo_o     out  DATA_W  LO: product[W-1:0] / quotient
// BEHAVIOUR
// - Reset: state=IDLE, busy_o=0, done_o=0, hi_o=0, lo_o=0, counter=0.
// - FSM: IDLE -> RUN on start_i & ~flush_i.
//   RUN -> FIX after DATA_W iterations. FIX -> IDLE.
// - Cycle T: start_i high in IDLE. At edge T the unit latches op and
//   |operands| (signed ops use magnitudes and record result signs).
// - Cycles T+1..T+DATA_W: RUN, one iteration per cycle; 6-bit counter.
//   Cycle T+DATA_W+1: FIX. busy_o is high for DATA_W+1 cycles.
// - Edge ending FIX: hi_o/lo_o load sign-corrected results. done_o=1 in
//   cycle T+DATA_W+2 (state IDLE, busy_o=0).
//   A start_i in that same cycle is accepted (back-to-back).
// - Sign rules: MULT product negative iff signs differ.
//   DIV quotient sign = sign(a)^sign(b); remainder takes sign(a).
// - Div by zero (data2_i==0): no trap. lo_o=all ones, hi_o=dividend.
//   Same latency as a normal divide.
// - Signed overflow (-2^(W-1) / -1): lo_o=-2^(W-1), hi_o=0.
// - start_i while busy_o=1: ignored; in-flight op unaffected.
// - flush_i in RUN/FIX: next state IDLE, no done_o, hi_o/lo_o keep
//   their old values. flush_i with start_i in IDLE: flush wins, no launch.
// - rst_i mid-operation: full reset values next cycle; reset overrides
//   flush_i and start_i.
// - hi_o/lo_o change only at the edge ending FIX or on reset.
// STRUCTURE
// - Package ex_muldiv_pkg: OP_MULT/OP_MULTU/OP_DIV/OP_DIVU constants,
//   state encoding (IDLE/RUN/FIX), DATA_W default.
// - Sub-module muldiv_sign_fix (combinational): applies the negate-on-
//   sign, div-by-zero and overflow rules to the raw magnitudes.
// - The top holds the FSM, counter and the 2*DATA_W shift register.
// TESTING
// - MULT 7 * -3 -> after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB,
//   busy high 33 cycles, done pulses once.
// - MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
// - DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//   DIVU 100/7 -> lo=14, hi=2.
// - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
//   DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
// - MULTU 3*4 with flush_i at RUN cycle 10 -> busy drops next cycle,
//   no done, hi/lo keep prior values. A second start_i during RUN is
//   ignored.
// - Back-to-back: start_i in the done_o cycle -> second op completes
//   exactly 34 cycles later. rst_i mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: op codes, FSM states, default width.
package ex_muldiv_pkg;

   localparam int unsigned DATA_W_DEF = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } state_e;

endpackage

// File: rtl/ex_muldiv_sign_fix.sv
// Turns the unsigned iteration results into final HI/LO values.
// Handles result signs, divide by zero and the signed divide overflow case.
module muldiv_sign_fix
   import ex_muldiv_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              is_div,
   input  logic              neg_q,
   input  logic              neg_r,
   input  logic              div_zero,
   input  logic              ovf,
   input  logic [DATA_W-1:0] raw_hi,
   input  logic [DATA_W-1:0] raw_lo,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   logic [2*DATA_W-1:0] prod;

   always_comb begin
      prod = {raw_hi, raw_lo};
      hi   = raw_hi;
      lo   = raw_lo;
      if (!is_div) begin
         if (neg_q) prod = -prod;
         hi = prod[2*DATA_W-1:DATA_W];
         lo = prod[DATA_W-1:0];
      end else if (div_zero) begin
         // remainder magnitude is |dividend|; re-signing restores the dividend
         lo = '1;
         hi = neg_r ? -raw_hi : raw_hi;
      end else if (ovf) begin
         lo = {1'b1, {(DATA_W-1){1'b0}}};
         hi = '0;
      end else begin
         lo = neg_q ? -raw_lo : raw_lo;
         hi = neg_r ? -raw_hi : raw_hi;
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU (shift-add) and DIV/DIVU (restoring) unit, one bit per cycle.
// busy_o stalls the pipeline from launch until the result lands in HI/LO.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] data1_i,
   input  logic [DATA_W-1:0] data2_i,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

   state_e              state, state_next;
   logic [CNT_W-1:0]    cnt;
   logic [2*DATA_W-1:0] acc, acc_step;
   logic [DATA_W-1:0]   opnd;
   logic                is_div, neg_q, neg_r, div_zero, ovf;
   logic                launch, last_iter;
   logic                a_neg, b_neg;
   logic [DATA_W-1:0]   mag_a, mag_b;
   logic [DATA_W:0]     sum, trial;
   logic [DATA_W-1:0]   fix_hi, fix_lo;

   assign a_neg     = ~op_i[0] & data1_i[DATA_W-1];
   assign b_neg     = ~op_i[0] & data2_i[DATA_W-1];
   assign mag_a     = a_neg ? -data1_i : data1_i;
   assign mag_b     = b_neg ? -data2_i : data2_i;
   assign launch    = (state == IDLE) & start_i & ~flush_i;
   assign last_iter = (cnt == CNT_W'(DATA_W - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (launch) state_next = RUN;
         RUN:     if (flush_i) state_next = IDLE;
                  else if (last_iter) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state != IDLE);
   end

   // acc = {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      sum      = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, opnd};
      trial    = acc[2*DATA_W-1:DATA_W-1] - {1'b0, opnd};
      acc_step = acc;
      if (!is_div)
         acc_step = acc[0] ? {sum, acc[DATA_W-1:1]} : {1'b0, acc[2*DATA_W-1:1]};
      else if (!trial[DATA_W])
         acc_step = {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      else
         acc_step = {acc[2*DATA_W-2:0], 1'b0};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         ovf      <= 1'b0;
         done_o   <= 1'b0;
         hi_o     <= '0;
         lo_o     <= '0;
      end else begin
         done_o <= (state == FIX) & ~flush_i;
         if (launch) begin
            cnt      <= '0;
            acc      <= {{DATA_W{1'b0}}, (op_i[1] ? mag_a : mag_b)};
            opnd     <= op_i[1] ? mag_b : mag_a;
            is_div   <= op_i[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= op_i[1] & (data2_i == '0);
            ovf      <= (op_i == OP_DIV) & (data1_i == {1'b1, {(DATA_W-1){1'b0}}})
                        & (data2_i == '1);
         end else if (state == RUN) begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
         end
         if ((state == FIX) && !flush_i) begin
            hi_o <= fix_hi;
            lo_o <= fix_lo;
         end
      end
   end

   muldiv_sign_fix #(.DATA_W(DATA_W)) u_sign_fix (
      .is_div   (is_div),
      .neg_q    (neg_q),
      .neg_r    (neg_r),
      .div_zero (div_zero),
      .ovf      (ovf),
      .raw_hi   (acc[2*DATA_W-1:DATA_W]),
      .raw_lo   (acc[DATA_W-1:0]),
      .hi       (fix_hi),
      .lo       (fix_lo)
   );

endmodule
